agc_level_detector: RTL

Measurement stage directly upstream of the AGC gain loop. Takes the post-gain signed sample stream and computes the mean absolute level over a fixed window of 2^LOG2_WIN accepted samples. Presents the result as a held `io_Vout` for the AGC comparator, with a completion strobe and a window overload flag. `io_Vout` changes only at window boundaries, so the AGC sees a stable measurement between updates.

---
 rtl/agc_pkg.sv | 27 ++
 rtl/agc_abs_sat.sv | 31 +++
 rtl/agc_level_detector.sv | 124 ++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// Shared AGC definitions: datapath width, default gain and clip threshold,
// level-detector state encoding and the saturating magnitude helper.
package agc_pkg;

  localparam int AGC_WIDTH = 19;
  localparam logic [AGC_WIDTH-1:0] AGC_G_RESET      = 19'h04000;
  localparam logic [AGC_WIDTH-1:0] AGC_CLIP_DEFAULT = 19'h3C000;

  typedef enum logic [0:0] {
    DET_FILL = 1'b0,
    DET_RUN  = 1'b1
  } det_state_e;

  // The most negative code has no positive twin, so it folds onto full scale.
  function automatic logic [AGC_WIDTH-2:0] abs_sat(input logic [AGC_WIDTH-1:0] x);
    logic [AGC_WIDTH-2:0] mag;
    if (x == {1'b1, {(AGC_WIDTH-1){1'b0}}}) begin
      mag = '1;
    end else if (x[AGC_WIDTH-1]) begin
      mag = ~x[AGC_WIDTH-2:0] + (AGC_WIDTH-1)'(1);
    end else begin
      mag = x[AGC_WIDTH-2:0];
    end
    return mag;
  endfunction

endpackage

// File: rtl/agc_abs_sat.sv
// Combinational saturating magnitude of a signed sample plus the overload
// compare against the clip threshold.
module agc_abs_sat
  import agc_pkg::*;
#(
  parameter int                WIDTH = AGC_WIDTH,
  parameter logic [WIDTH-1:0]  CLIP  = AGC_CLIP_DEFAULT
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-2:0] o_abs,
  output logic             o_clip
);

  logic [WIDTH-2:0] w_abs;

  // Magnitude with -2^(WIDTH-1) saturated to 2^(WIDTH-1)-1.
  always_comb begin
    w_abs = i_in[WIDTH-2:0];
    if (i_in == {1'b1, {(WIDTH-1){1'b0}}}) begin
      w_abs = '1;
    end else if (i_in[WIDTH-1]) begin
      w_abs = ~i_in[WIDTH-2:0] + (WIDTH-1)'(1);
    end else begin
      w_abs = i_in[WIDTH-2:0];
    end
  end

  assign o_abs  = w_abs;
  assign o_clip = ({1'b0, w_abs} >= CLIP);

endmodule

// File: rtl/agc_level_detector.sv
// Mean absolute level over a window of 2^LOG2_WIN accepted samples, held
// between window boundaries for the AGC comparator, with overload flag.
module agc_level_detector
  import agc_pkg::*;
#(
  parameter int               WIDTH    = AGC_WIDTH,
  parameter int               LOG2_WIN = 4,
  parameter logic [WIDTH-1:0] CLIP     = AGC_CLIP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  input  logic             io_in_valid,
  input  logic             io_clear,
  output logic [WIDTH-1:0] io_Vout,
  output logic             io_Vout_valid,
  output logic             io_overload
);

  localparam int                  ACC_W   = WIDTH - 1 + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_MAX = '1;

  logic [WIDTH-2:0]    w_abs;
  logic                w_clip;
  logic [WIDTH-2:0]    r_abs_q;
  logic                r_abs_v;
  logic                r_clip_q;
  logic [ACC_W-1:0]    r_acc;
  logic [LOG2_WIN-1:0] r_cnt;
  logic                r_pk;
  logic [WIDTH-1:0]    r_vout;
  logic                r_vout_valid;
  logic                r_overload;
  logic [ACC_W-1:0]    w_sum;
  logic                w_win_end;
  det_state_e          r_state;
  det_state_e          w_state_next;

  agc_abs_sat #(
    .WIDTH (WIDTH),
    .CLIP  (CLIP)
  ) u_abs_sat (
    .i_in   (io_in),
    .o_abs  (w_abs),
    .o_clip (w_clip)
  );

  assign w_sum     = r_acc + ACC_W'(r_abs_q);
  assign w_win_end = r_abs_v && (r_cnt == CNT_MAX);

  // Stage 1: register magnitude, clip flag and qualifier; clear drops the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_abs_q  <= '0;
      r_clip_q <= 1'b0;
      r_abs_v  <= 1'b0;
    end else if (io_clear) begin
      r_abs_q  <= w_abs;
      r_clip_q <= w_clip;
      r_abs_v  <= 1'b0;
    end else begin
      r_abs_q  <= w_abs;
      r_clip_q <= w_clip;
      r_abs_v  <= io_in_valid;
    end
  end

  // Stage 2: window accumulation; results publish only on a completed window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_pk         <= 1'b0;
      r_vout       <= '0;
      r_vout_valid <= 1'b0;
      r_overload   <= 1'b0;
    end else if (io_clear) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_pk         <= 1'b0;
      r_vout_valid <= 1'b0;
    end else if (w_win_end) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_pk         <= 1'b0;
      r_vout       <= WIDTH'(w_sum >> LOG2_WIN);
      r_overload   <= r_pk | r_clip_q;
      r_vout_valid <= 1'b1;
    end else if (r_abs_v) begin
      r_acc        <= w_sum;
      r_cnt        <= r_cnt + LOG2_WIN'(1);
      r_pk         <= r_pk | r_clip_q;
      r_vout_valid <= 1'b0;
    end else begin
      r_vout_valid <= 1'b0;
    end
  end

  // Window-progress state register, observed for debug only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DET_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: clear restarts filling, first completed window enters RUN.
  always_comb begin
    w_state_next = r_state;
    if (io_clear) begin
      w_state_next = DET_FILL;
    end else if (w_win_end) begin
      w_state_next = DET_RUN;
    end else begin
      w_state_next = r_state;
    end
  end

  assign io_Vout       = r_vout;
  assign io_Vout_valid = r_vout_valid;
  assign io_overload   = r_overload;

endmodule
